// File: rtl/ppa_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer and its chunk adder.
package ppa_pkg;

   localparam int CHUNK_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/PPA_adder.sv
// 6-bit combinational parallel-prefix (Kogge-Stone) adder with carry-in and carry-out.
module PPA_adder
   import ppa_pkg::*;
(
   input  logic [CHUNK_W-1:0] a,
   input  logic [CHUNK_W-1:0] b,
   input  logic               c_in,
   output logic [CHUNK_W-1:0] sum,
   output logic               c_out
);

   logic [CHUNK_W-1:0] g_s [0:3];
   logic [CHUNK_W-1:0] p_s [0:3];
   logic [CHUNK_W-1:0] carry_s;

   // Prefix tree: c_in is folded into bit 0 so g_s[3][i] is the carry out of bit i.
   always_comb begin
      p_s[0] = a ^ b;
      g_s[0] = a & b;
      g_s[0][0] = g_s[0][0] | (p_s[0][0] & c_in);
      for (int l = 0; l < 3; l++) begin
         g_s[l+1] = g_s[l] | (p_s[l] & (g_s[l] << (1 << l)));
         p_s[l+1] = p_s[l] & ((p_s[l] << (1 << l)) | CHUNK_W'((1 << (1 << l)) - 1));
      end
      carry_s = {g_s[3][CHUNK_W-2:0], c_in};
      sum     = p_s[0] ^ carry_s;
      c_out   = g_s[3][CHUNK_W-1];
   end

endmodule

// File: rtl/ppa_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 6-bit PPA_adder, one chunk per clock, LS chunk first.
module ppa_mp_add_seq
   import ppa_pkg::*;
#(
   parameter  int WORDS = 4,
   localparam int W     = CHUNK_W * WORDS
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic         c_in,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         c_out,
   output logic         ovf
);

   localparam int            IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   seq_state_t         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       result_q, result_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;

   logic [CHUNK_W-1:0] a_chunk_s;
   logic [CHUNK_W-1:0] b_chunk_s;
   logic [CHUNK_W-1:0] sum_s;
   logic               add_co_s;

   assign a_chunk_s = a_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
   assign b_chunk_s = b_q[int'(idx_q) * CHUNK_W +: CHUNK_W];

   PPA_adder u_adder (
      .a     (a_chunk_s),
      .b     (b_chunk_s),
      .c_in  (carry_q),
      .sum   (sum_s),
      .c_out (add_co_s)
   );

   // Next-state logic: operand staging, chunk write-back, carry chain and final flags.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = sub ? ~op_b : op_b;
               carry_d = sub ? 1'b1 : c_in;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               result_d[int'(idx_q) * CHUNK_W +: CHUNK_W] = sum_s;
               carry_d = add_co_s;
               if (idx_q == LAST_IDX) begin
                  c_out_d = add_co_s;
                  ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_s[CHUNK_W-1] != a_q[W-1]);
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign c_out  = c_out_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_ppa_mp_add_seq.sv
// Self-checking bench: directed cases on WORDS=4, random scoreboard on WORDS=1,4,7 against an arithmetic model.
module tb_ppa_mp_add_seq;

   localparam int WMAX = 42;

   logic            clk = 1'b0;
   logic            rst_n, start, sub, c_in, abort;
   logic [WMAX-1:0] op_a, op_b;

   logic        busy1, done1, co1, ov1;
   logic [5:0]  res1;
   logic        busy4, done4, co4, ov4;
   logic [23:0] res4;
   logic        busy7, done7, co7, ov7;
   logic [41:0] res7;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   ppa_mp_add_seq #(.WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .c_in(c_in),
      .op_a(op_a[5:0]), .op_b(op_b[5:0]), .abort(abort),
      .busy(busy1), .done(done1), .result(res1), .c_out(co1), .ovf(ov1));

   ppa_mp_add_seq #(.WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .c_in(c_in),
      .op_a(op_a[23:0]), .op_b(op_b[23:0]), .abort(abort),
      .busy(busy4), .done(done4), .result(res4), .c_out(co4), .ovf(ov4));

   ppa_mp_add_seq #(.WORDS(7)) dut7 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .c_in(c_in),
      .op_a(op_a), .op_b(op_b), .abort(abort),
      .busy(busy7), .done(done7), .result(res7), .c_out(co7), .ovf(ov7));

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arithmetic at width w: modular result, carry/no-borrow, true signed overflow.
   function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic ci,
                                  output logic [63:0] r, output logic co, output logic ov);
      longint unsigned m, u;
      longint          sa, sb, sv, lo, hi;
      m  = (64'd1 << w) - 64'd1;
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
      if (!s) begin
         u  = a + b + {63'd0, ci};
         r  = u & m;
         co = ((u >> w) & 64'd1) != 64'd0;
         sv = sa + sb + longint'(ci);
      end else begin
         u  = a - b;
         r  = u & m;
         co = (a >= b);
         sv = sa - sb;
      end
      ov = (sv < lo) || (sv > hi);
   endfunction

   task automatic run4(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic s, input logic ci,
                       input logic [23:0] exp_r, input logic exp_co, input logic exp_ov);
      int k;
      op_a  = {18'd0, a};
      op_b  = {18'd0, b};
      sub   = s;
      c_in  = ci;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq({tag, "_busy"}, {63'd0, busy4}, 64'd1);
      k = 0;
      while (!done4 && k < 20) begin
         tick();
         k++;
      end
      check_eq({tag, "_lat"}, 64'(k), 64'd4);
      check_eq({tag, "_res"}, {40'd0, res4}, {40'd0, exp_r});
      check_eq({tag, "_flags"}, {62'd0, co4, ov4}, {62'd0, exp_co, exp_ov});
      check_eq({tag, "_busy_at_done"}, {63'd0, busy4}, 64'd0);
      tick();
      check_eq({tag, "_done_pulse"}, {63'd0, done4}, 64'd0);
   endtask

   initial begin
      logic [63:0] r;
      logic        co, ov, s, ci;
      logic [41:0] a, b;
      int          k, ndone, k1, k4, k7;
      logic [23:0] cap;

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; c_in = 1'b0; abort = 1'b0;
      op_a = '0; op_b = '0;
      tick();
      tick();
      rst_n = 1'b1;
      check_eq("reset_state", {35'd0, busy4, done4, co4, ov4, res4}, 64'd0);

      run4("add_carry_ripple", 24'h000FFF, 24'h000001, 1'b0, 1'b0, 24'h001000, 1'b0, 1'b0);
      run4("add_pos_ovf",      24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
      run4("add_wrap_cin",     24'hFFFFFF, 24'h000001, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b0);
      run4("sub_borrow",       24'h000005, 24'h000007, 1'b1, 1'b0, 24'hFFFFFE, 1'b0, 1'b0);
      run4("sub_neg_ovf",      24'h800000, 24'h000001, 1'b1, 1'b0, 24'h7FFFFF, 1'b1, 1'b1);

      // start pulses during RUN (edge T+2) and during DONE (edge T+5) must be ignored
      op_a = 42'h123456; op_b = 42'h111111; sub = 1'b0; c_in = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      cap   = '0;
      for (int i = 1; i <= 14; i++) begin
         if (i == 2 || i == 5) begin
            op_a  = 42'h0F0F0F;
            op_b  = 42'h00000A;
            sub   = 1'b1;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         if (done4) begin
            ndone++;
            cap = res4;
         end
      end
      check_eq("ign_start_ndone", 64'(ndone), 64'd1);
      check_eq("ign_start_res", {40'd0, cap}, 64'h234567);
      check_eq("ign_start_idle", {63'd0, busy4}, 64'd0);

      // abort sampled at edge T+2, new command accepted at edge T+3
      op_a = 42'h00ABCD; op_b = 42'h001111; sub = 1'b0; c_in = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", {62'd0, busy4, done4}, 64'd0);
      run4("after_abort", 24'h400000, 24'h3FFFFF, 1'b1, 1'b1, 24'h000001, 1'b1, 1'b0);

      // reset asserted mid-RUN at edge T+3
      op_a = 42'h555555; op_b = 42'h2AAAAA; sub = 1'b0; c_in = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("midrun_reset", {35'd0, busy4, done4, co4, ov4, res4}, 64'd0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done4) ndone++;
      end
      check_eq("midrun_reset_nodone", 64'(ndone), 64'd0);

      // random scoreboard across WORDS = 1, 4, 7
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: a = '1;
            1: b = '1;
            2: b = '0;
            3: b = a;
            4: begin a[41] = 1'b1; a[23] = 1'b1; a[5] = 1'b1; end
            default: ;
         endcase
         s  = 1'($urandom_range(0, 1));
         ci = 1'($urandom_range(0, 1));
         op_a = a; op_b = b; sub = s; c_in = ci;
         start = 1'b1;
         tick();
         start = 1'b0;
         k1 = 0; k4 = 0; k7 = 0;
         k  = 0;
         while ((k1 == 0 || k4 == 0 || k7 == 0) && k < 12) begin
            tick();
            k++;
            if (done1 && k1 == 0) begin
               k1 = k;
               ref_op(6, {58'd0, a[5:0]}, {58'd0, b[5:0]}, s, ci, r, co, ov);
               check_eq("rnd_w1", {56'd0, res1, co1, ov1}, {r[55:0], co, ov});
            end
            if (done4 && k4 == 0) begin
               k4 = k;
               ref_op(24, {40'd0, a[23:0]}, {40'd0, b[23:0]}, s, ci, r, co, ov);
               check_eq("rnd_w4", {38'd0, res4, co4, ov4}, {r[61:0], co, ov});
            end
            if (done7 && k7 == 0) begin
               k7 = k;
               ref_op(42, {22'd0, a}, {22'd0, b}, s, ci, r, co, ov);
               check_eq("rnd_w7", {20'd0, res7, co7, ov7}, {r[61:0], co, ov});
            end
         end
         check_eq("rnd_latency", {40'(k1), 12'(k4), 12'(k7)}, {40'd1, 12'd4, 12'd7});
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
